// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and shadow-entry types for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // ALU operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Per-entry control bits travelling alongside the destination tag
    typedef struct packed {
        logic wr_en;
        logic is_load;
    } entry_flags_t;

    localparam int unsigned ENTRY_FLAG_W = 2;
    localparam int unsigned REG_ZERO     = 0;

    // Total shadow-entry width for a given register index width
    function automatic int unsigned entry_width(input int unsigned reg_w);
        return reg_w + ENTRY_FLAG_W;
    endfunction

endpackage

// File: rtl/dst_shadow_stage.sv
// One shadow-pipeline entry: destination tag plus write/load flags.
// Loads a bubble (no write, not a load, r0) on reset or on request.
module dst_shadow_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                insert_bubble,
    input  logic [REG_W-1:0]    next_dst,
    input  entry_flags_t        next_flags,
    output logic [REG_W-1:0]    dst,
    output entry_flags_t        flags
);

    // Advance the entry every cycle, substituting a bubble when requested
    always_ff @(posedge clk) begin
        if (reset || insert_bubble) begin
            dst   <= '0;
            flags <= '0;
        end else begin
            dst   <= next_dst;
            flags <= next_flags;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: shadow destination tags for
// EX/MEM/WB, load-use and dependence stalls, branch flush, operand forwarding.
// Optional feature macro: PIPE_FORWARDING_EN (defined: forwarding paths used;
// undefined: any live dependence interlocks until the producer leaves WB).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    logic [REG_W-1:0] ex_dst, mem_dst, wb_dst;
    entry_flags_t     ex_flags, mem_flags, wb_flags, id_flags;
    logic             ex_live, mem_live, wb_live;
    logic             a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic             load_use, stall_req, ex_bubble;
    logic [1:0]       flush_ctr;
    logic             unused_wb_load;

    function automatic logic is_live(input logic [REG_W-1:0] dst, input entry_flags_t f);
        return f.wr_en && (dst != REG_W'(REG_ZERO));
    endfunction

    function automatic logic src_match(input logic valid, input logic used,
                                       input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst, input logic live);
        return valid && used && (src != REG_W'(REG_ZERO)) && (src == dst) && live;
    endfunction

`ifdef PIPE_FORWARDING_EN
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit,
                                          input logic wb_hit);
        if (ex_hit)       return FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else if (wb_hit)  return FWD_WB;
        else              return FWD_REG;
    endfunction
`endif

    assign id_flags       = '{wr_en: id_wr_en, is_load: id_is_load};
    assign ex_bubble      = ~(id_valid & ~stall_if & ~flush_id);
    assign unused_wb_load = wb_flags.is_load;

    dst_shadow_stage #(.REG_W(REG_W)) u_ex (
        .clk(clk), .reset(reset), .insert_bubble(ex_bubble),
        .next_dst(id_dst), .next_flags(id_flags), .dst(ex_dst), .flags(ex_flags)
    );

    dst_shadow_stage #(.REG_W(REG_W)) u_mem (
        .clk(clk), .reset(reset), .insert_bubble(1'b0),
        .next_dst(ex_dst), .next_flags(ex_flags), .dst(mem_dst), .flags(mem_flags)
    );

    dst_shadow_stage #(.REG_W(REG_W)) u_wb (
        .clk(clk), .reset(reset), .insert_bubble(1'b0),
        .next_dst(mem_dst), .next_flags(mem_flags), .dst(wb_dst), .flags(wb_flags)
    );

    // Source-versus-stage dependence detection
    always_comb begin
        ex_live  = is_live(ex_dst, ex_flags);
        mem_live = is_live(mem_dst, mem_flags);
        wb_live  = is_live(wb_dst, wb_flags);
        a_ex     = src_match(id_valid, id_uses_rs, id_rs, ex_dst,  ex_live);
        a_mem    = src_match(id_valid, id_uses_rs, id_rs, mem_dst, mem_live);
        a_wb     = src_match(id_valid, id_uses_rs, id_rs, wb_dst,  wb_live);
        b_ex     = src_match(id_valid, id_uses_rt, id_rt, ex_dst,  ex_live);
        b_mem    = src_match(id_valid, id_uses_rt, id_rt, mem_dst, mem_live);
        b_wb     = src_match(id_valid, id_uses_rt, id_rt, wb_dst,  wb_live);
        load_use = ex_flags.is_load & (a_ex | b_ex);
    end

    // Stall/flush/forward decisions; flush takes priority over stall
    always_comb begin
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
`ifdef PIPE_FORWARDING_EN
        stall_req = load_use;
        // A loaded value is not ready in EX, so an EX load match never selects EX
        fwd_a_sel = fwd_pick(a_ex & ~ex_flags.is_load, a_mem, a_wb);
        fwd_b_sel = fwd_pick(b_ex & ~ex_flags.is_load, b_mem, b_wb);
`else
        stall_req = load_use | a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
`endif
        flush_id  = ex_branch_taken | (flush_ctr != '0);
        stall_if  = stall_req & ~flush_id;
        bubble_ex = stall_if | flush_id;
    end

    // Flush down-counter: a taken branch (re)loads the remaining squash cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_ctr <= '0;
        end else if (ex_branch_taken) begin
            flush_ctr <= 2'(FLUSH_DEPTH - 1);
        end else if (flush_ctr != '0) begin
            flush_ctr <= flush_ctr - 2'd1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (ex_branch_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default parameters).
// Expectations follow the PIPE_FORWARDING_EN macro when it is defined.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
    logic        ex_branch_taken;
    logic        stall_if, bubble_ex, flush_id;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_DEPTH(2), .PERF_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [4:0] dst,
                            input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_wr_en = wr; id_is_load = ld;
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_branch_taken = 1'b0; idle();
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_if); end
        checks++; if (bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b exp 0", bubble_ex); end
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush_id); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got %b exp 00", fwd_b_sel); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
    endtask

`ifdef PIPE_FORWARDING_EN
    // add r3,r1,r2 ; sub r4,r3,r5 ; then a consumer of r4 (EX) and r3 (MEM)
    task automatic test_forward();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_ex_a got %b exp 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_ex_b got %b exp 00", fwd_b_sel); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall got %b exp 0", stall_if); end
        step();
        drive_id(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_pri_a got %b exp 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fwd_mem_b got %b exp 10", fwd_b_sel); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL fwd_stall_cnt got %0d exp 0", stall_cnt); end
        idle();
    endtask
`else
    // add r3,r1,r2 ; sub r4,r3,r5 interlocks for three cycles
    task automatic test_interlock();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL ilk_first got %b exp 0", stall_if); end
        step();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL ilk_stall c%0d got %b exp 1", i, stall_if); end
            checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL ilk_bubble c%0d got %b exp 1", i, bubble_ex); end
            step();
        end
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL ilk_issue got %b exp 0", stall_if); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL ilk_fwd_a got %b exp 00", fwd_a_sel); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL ilk_stall_cnt got %0d exp 3", stall_cnt); end
        idle();
    endtask
`endif

    // load r6 ; add r7,r6,r1
    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall_if); end
        checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b exp 1", bubble_ex); end
        step();
`ifdef PIPE_FORWARDING_EN
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall_if); end
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_a got %b exp 10", fwd_a_sel); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
`else
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL lu_mem_stall got %b exp 1", stall_if); end
        step();
        step();
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall_if); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 3", stall_cnt); end
`endif
        idle();
    endtask

    // add r0,r1,r2 ; add r4,r0,r0 never hazards
    task automatic test_r0();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL r0_stall got %b exp 0", stall_if); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL r0_fwd_a got %b exp 00", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL r0_fwd_b got %b exp 00", fwd_b_sel); end
        idle();
    endtask

    // taken branch while a load-use is pending: flush wins for 2 cycles
    task automatic test_flush();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL fl_c0_flush got %b exp 1", flush_id); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fl_c0_stall got %b exp 0", stall_if); end
        checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL fl_c0_bubble got %b exp 1", bubble_ex); end
        step();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL fl_c1_flush got %b exp 1", flush_id); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fl_c1_stall got %b exp 0", stall_if); end
        step();
        #1;
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL fl_c2_flush got %b exp 0", flush_id); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL fl_flush_cnt got %0d exp 1", flush_cnt); end
`ifdef PIPE_FORWARDING_EN
        checks++; if (fwd_a_sel !== 2'b11) begin errors++; $display("FAIL fl_fwd_wb got %b exp 11", fwd_a_sel); end
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fl_c2_stall got %b exp 0", stall_if); end
`else
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fl_c2_stall got %b exp 1", stall_if); end
`endif
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_stall_cnt got %0d exp 0", stall_cnt); end
        idle();
    endtask

    // two consecutive taken branches reload the counter
    task automatic test_back_to_back();
        do_reset();
        ex_branch_taken = 1'b1;
        step();
        step();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (flush_id !== 1'b1) begin errors++; $display("FAIL b2b_tail got %b exp 1", flush_id); end
        step();
        #1;
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", flush_id); end
        checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL b2b_flush_cnt got %0d exp 2", flush_cnt); end
    endtask

    // reset asserted during a load-use stall
    task automatic test_reset_mid_stall();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL rms_pre got %b exp 1", stall_if); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL rms_stall got %b exp 0", stall_if); end
        checks++; if (bubble_ex !== 1'b0) begin errors++; $display("FAIL rms_bubble got %b exp 0", bubble_ex); end
        checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL rms_flush got %b exp 0", flush_id); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rms_fwd_a got %b exp 00", fwd_a_sel); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rms_stall_cnt got %0d exp 0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rms_flush_cnt got %0d exp 0", flush_cnt); end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        test_reset();
`ifdef PIPE_FORWARDING_EN
        test_forward();
`else
        test_interlock();
`endif
        test_load_use();
        test_r0();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
